carregador_instrucoes: RTL and testbench

//  Boot loader that writes the nRisc instruction memory (bancoInstrucoes) at
//  run time, replacing the simulation-only preload. It accepts a framed byte

---
 rtl/carregador_instrucoes.sv | 156 +++++++++++++++
 tb/tb_carregador_instrucoes.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_instrucoes.sv
// Boot loader for the nRisc instruction memory (bancoInstrucoes).
// Receives a framed byte stream (LEN, N payload bytes, CHK) on a valid/ready
// interface. Each payload byte becomes one instruction memory write one cycle
// after it is accepted. The processor is held in reset until a frame with a
// matching checksum has been completely loaded.
module carregador_instrucoes #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int PROG_MAX = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [DATA_W-1:0] in_dado,
  input  logic              in_valido,
  output logic              in_pronto,
  output logic [ADDR_W-1:0] end_escrita,
  output logic [DATA_W-1:0] dado_escrita,
  output logic              escreve_inst,
  output logic              proc_reset,
  output logic              ocupado,
  output logic              concluido,
  output logic              erro
);

  localparam logic [DATA_W-1:0] PROG_MAX_B = DATA_W'(PROG_MAX);

  typedef enum logic [2:0] {
    OCIOSO,
    TAMANHO,
    CARGA,
    CHECK,
    FIM,
    ERRO
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic              aceita;
  logic              ultimo;

  // State and datapath registers; reset wins over any transfer on the same edge,
  // so a write that would follow a byte accepted while reset is high never issues.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      len_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      dado_q   <= '0;
    end else begin
      estado_q <= estado_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      dado_q   <= dado_d;
    end
  end

  // Next-state, datapath updates and state-decoded status outputs.
  always_comb begin
    estado_d   = estado_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    dado_d     = dado_q;
    concluido  = 1'b0;
    erro       = 1'b0;
    proc_reset = 1'b1;

    in_pronto = (estado_q == TAMANHO) || (estado_q == CARGA) || (estado_q == CHECK);
    ocupado   = in_pronto;
    aceita    = in_valido && in_pronto;
    // Counter holds the index of the byte being accepted; the N-th byte is index N-1.
    ultimo    = (cnt_q == ADDR_W'(len_q - DATA_W'(1)));

    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          estado_d = TAMANHO;
          sum_d    = '0;
          cnt_d    = '0;
        end
      end

      TAMANHO: begin
        if (aceita) begin
          if ((in_dado == '0) || (in_dado > PROG_MAX_B)) begin
            estado_d = ERRO;
          end else begin
            len_d    = in_dado;
            estado_d = CARGA;
          end
        end
      end

      CARGA: begin
        if (aceita) begin
          sum_d  = sum_q + in_dado;
          wr_d   = 1'b1;
          addr_d = cnt_q;
          dado_d = in_dado;
          cnt_d  = cnt_q + ADDR_W'(1);
          if (ultimo) begin
            estado_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (aceita) begin
          estado_d = (in_dado == sum_q) ? FIM : ERRO;
        end
      end

      FIM: begin
        concluido  = 1'b1;
        proc_reset = 1'b0;
        if (iniciar) begin
          estado_d = TAMANHO;
          sum_d    = '0;
          cnt_d    = '0;
        end
      end

      ERRO: begin
        erro = 1'b1;
        if (iniciar) begin
          estado_d = TAMANHO;
          sum_d    = '0;
          cnt_d    = '0;
        end
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign escreve_inst = wr_q;
  assign end_escrita  = addr_q;
  assign dado_escrita = dado_q;

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Directed bench for carregador_instrucoes: expected instruction memory writes
// are queued as payload bytes are offered and popped as writes appear.
module tb_carregador_instrucoes;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [7:0] in_dado;
  logic       in_valido;
  logic       in_pronto;
  logic [7:0] end_escrita;
  logic [7:0] dado_escrita;
  logic       escreve_inst;
  logic       proc_reset;
  logic       ocupado;
  logic       concluido;
  logic       erro;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [15:0] exp_q[$];

  carregador_instrucoes #(.DATA_W(8), .ADDR_W(8), .PROG_MAX(12)) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .in_dado     (in_dado),
    .in_valido   (in_valido),
    .in_pronto   (in_pronto),
    .end_escrita (end_escrita),
    .dado_escrita(dado_escrita),
    .escreve_inst(escreve_inst),
    .proc_reset  (proc_reset),
    .ocupado     (ocupado),
    .concluido   (concluido),
    .erro        (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    if (escreve_inst === 1'b1) begin
      wr_count++;
      check("wr_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        check("wr_addr_data", {16'd0, end_escrita, dado_escrita}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  // Offer one byte and hold it until accepted; payload bytes queue a write.
  task automatic send_byte(input logic [7:0] b, input bit payload, input int addr);
    int waited = 0;
    @(negedge clock);
    in_valido = 1'b1;
    in_dado   = b;
    while (in_pronto !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 20) begin
      check("accept_timeout", 32'(waited), 32'd0);
    end else if (payload) begin
      exp_q.push_back({addr[7:0], b});
    end
    @(posedge clock);
    #1;
    in_valido = 1'b0;
    in_dado   = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] data [16],
                            input int n, input logic [7:0] chk);
    send_byte(len, 1'b0, 0);
    for (int i = 0; i < n; i++) send_byte(data[i], 1'b1, i);
    send_byte(chk, 1'b0, 0);
  endtask

  task automatic drain();
    repeat (3) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic status(input string tag, input logic c, input logic e, input logic p);
    check({tag, "_concluido"}, {31'd0, concluido}, {31'd0, c});
    check({tag, "_erro"}, {31'd0, erro}, {31'd0, e});
    check({tag, "_proc_reset"}, {31'd0, proc_reset}, {31'd0, p});
  endtask

  logic [7:0] d [16];
  int base;

  initial begin
    reset = 1'b1; iniciar = 1'b0; in_dado = 8'h00; in_valido = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_pronto", {31'd0, in_pronto}, 32'd0);
    check("rst_escreve", {31'd0, escreve_inst}, 32'd0);
    check("rst_end", {24'd0, end_escrita}, 32'd0);
    check("rst_dado", {24'd0, dado_escrita}, 32'd0);
    check("rst_ocupado", {31'd0, ocupado}, 32'd0);
    status("rst", 1'b0, 1'b0, 1'b1);

    // Valid while idle is ignored.
    in_valido = 1'b1; in_dado = 8'h03;
    repeat (2) @(negedge clock);
    in_valido = 1'b0;
    check("idle_ocupado", {31'd0, ocupado}, 32'd0);
    check("idle_writes", 32'(wr_count), 32'd0);

    // 1: good 3-byte frame.
    pulse_start();
    check("t1_ocupado", {31'd0, ocupado}, 32'd1);
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    send_frame(8'h03, d, 3, 8'h66);
    drain();
    status("t1", 1'b1, 1'b0, 1'b0);
    check("t1_writes", 32'(wr_count), 32'd3);
    check("t1_fim_pronto", {31'd0, in_pronto}, 32'd0);

    // 2: reload from FIM with bad checksum.
    pulse_start();
    check("t2_reload_proc_reset", {31'd0, proc_reset}, 32'd1);
    check("t2_reload_concluido", {31'd0, concluido}, 32'd0);
    send_frame(8'h03, d, 3, 8'h67);
    drain();
    status("t2", 1'b0, 1'b1, 1'b1);
    check("t2_writes", 32'(wr_count), 32'd6);

    // 3: LEN above PROG_MAX, then LEN zero.
    base = wr_count;
    pulse_start();
    send_byte(8'h0D, 1'b0, 0);
    drain();
    status("t3a", 1'b0, 1'b1, 1'b1);
    check("t3a_pronto", {31'd0, in_pronto}, 32'd0);
    pulse_start();
    send_byte(8'h00, 1'b0, 0);
    drain();
    status("t3b", 1'b0, 1'b1, 1'b1);
    check("t3_writes", 32'(wr_count - base), 32'd0);

    // 4: maximum-length frame.
    base = wr_count;
    for (int i = 0; i < 12; i++) d[i] = 8'hFF;
    pulse_start();
    send_frame(8'h0C, d, 12, 8'hF4);
    drain();
    status("t4", 1'b1, 1'b0, 1'b0);
    check("t4_writes", 32'(wr_count - base), 32'd12);

    // 5: valid every other cycle, iniciar pulsed mid-frame.
    base = wr_count;
    pulse_start();
    send_byte(8'h03, 1'b0, 0);
    @(negedge clock);
    send_byte(8'hAA, 1'b1, 0);
    pulse_start();
    check("t5_still_busy", {31'd0, ocupado}, 32'd1);
    send_byte(8'hBB, 1'b1, 1);
    @(negedge clock);
    send_byte(8'hCC, 1'b1, 2);
    @(negedge clock);
    send_byte(8'h31, 1'b0, 0);
    drain();
    status("t5", 1'b1, 1'b0, 1'b0);
    check("t5_writes", 32'(wr_count - base), 32'd3);

    // 6: reset after 2nd payload byte, coinciding with the 3rd byte offered.
    base = wr_count;
    pulse_start();
    send_byte(8'h03, 1'b0, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 1);
    @(negedge clock);
    reset = 1'b1; in_valido = 1'b1; in_dado = 8'h03;
    @(negedge clock);
    reset = 1'b0; in_valido = 1'b0;
    check("t6_rst_ocupado", {31'd0, ocupado}, 32'd0);
    check("t6_rst_escreve", {31'd0, escreve_inst}, 32'd0);
    check("t6_rst_end", {24'd0, end_escrita}, 32'd0);
    status("t6_rst", 1'b0, 1'b0, 1'b1);
    drain();
    check("t6_partial_writes", 32'(wr_count - base), 32'd2);
    d[0] = 8'h5A; d[1] = 8'hA5;
    pulse_start();
    send_frame(8'h02, d, 2, 8'hFF);
    drain();
    status("t6", 1'b1, 1'b0, 1'b0);
    check("t6_writes", 32'(wr_count - base), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
